fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the core, sitting directly upstream of the decode stage.
- Generates word addresses to a synchronous instruction memory with 1-cycle read latency.
- Captures returned instructions into a 2-entry buffer so decode stalls never lose or duplicate an instruction.
- Presents {valid, inst, origaddr} to decode.
- Redirects to a branch target from execute, flushing everything fetched on the old path.

Parameters:
ADDR_W, 16, instruction address width (word address)
INST_W, 32, instruction width
RESET_ADDR, 0, first fetch address after reset
ADDR_INC, 1, pc increment per fetched word

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-low (0 = reset, 1 = run)
branch_i  in  1  redirect request from execute, single-cycle pulse
baddr_i  in  ADDR_W  branch target, valid when branch_i=1
req_o  out  1  memory read request this cycle
addr_o  out  ADDR_W  memory read address (= pc register)
inst_i  in  INST_W  memory data for the request issued in the previous cycle
v_o  out  1  instruction valid to decode
inst_o  out  INST_W  instruction to decode (buffer head)
origaddr_o  out  ADDR_W  address of inst_o
stall_i  in  1  decode cannot accept this cycle

Behaviour:
- State: pc, inflight bit (request issued last cycle), inflight_addr, 2-entry FIFO of {inst, addr} with count 0..2.
- Reset (rst=0 at posedge):
  - pc←RESET_ADDR; count←0; inflight←0.
  - Reset overrides branch_i, stall_i and any returning inst_i.
  - During reset cycles req_o=0 and v_o=0; inst_o and origaddr_o are don't-care (0 after reset).
- pop = v_o & ~stall_i.
- v_o = (count≠0) & ~branch_i (combinational). inst_o/origaddr_o = FIFO head.
- issue = (count + inflight − pop) < 2. req_o = issue & ~branch_i & rst.
- On req_o: inflight←1, inflight_addr←pc, pc←pc+ADDR_INC (wraps modulo 2^ADDR_W). Otherwise inflight←0 and pc holds.
- Push: if inflight & ~branch_i, push {inst_i, inflight_addr} at the posedge ending that cycle.
- Push and pop in the same cycle are both permitted; head advances and the new entry appends.
- Overflow (push with count=2 and no pop) is impossible by construction. Verify with an assertion.
- Latency, stall-free: request in cycle n, data sampled at end of n+1, v_o high in n+2. Steady-state throughput is 1 instruction/cycle (count=1, inflight=1).
- Branch (branch_i=1 in cycle b):
  - v_o forced 0 in cycle b.
  - No request is issued in b.
  - Data returning in b is discarded.
  - FIFO flushed (count←0); pc←baddr_i.
  - Request for baddr_i issues in b+1; v_o with origaddr=baddr_i in b+3.
- Branch coinciding with stall, full FIFO, or pop: branch wins; no pop occurs.
- Stall: FIFO head held stable (inst_o/origaddr_o unchanged) while v_o & stall_i.
- No state machine beyond the counters; modes are implied by count/inflight.

Decomposition:
- ADDR_W, INST_W and RESET_ADDR defaults live in the shared params header used by every core stage, so decode, execute and memory agree on widths.
- One sub-module, fetch_fifo: 2-entry FIFO with push, pop, synchronous flush, count output and head data.
- pc/issue logic stays in fetch_stage.

Test Plan:
1. Reset low 2 cycles, then free-run with stall_i=0 and memory word k = 0xA000_0000+k.
   - Expected: req_o=1 every cycle from cycle 0 with addr_o 0,1,2…
   - v_o=1 from cycle 2 on, with origaddr_o 0,1,2… and inst_o matching.
2. Free-run, stall_i=1 cycles 5–8.
   - Expected: head stable during the stall; req_o drops once count+inflight=2.
   - After release, the origaddr sequence continues with no gap or repeat.
3. branch_i=1 in cycle 6, baddr_i=0x0040.
   - Expected: v_o=0 in cycles 6–8; req_o=0 in 6; addr_o=0x0040 with req_o=1 in 7.
   - v_o=1 with origaddr_o=0x0040 in 9; no old-path address ever appears afterward.
4. Fill the FIFO under stall, then branch_i while stall_i=1.
   - Expected: flush, same timing as scenario 3; the stalled head never pops.
5. RESET_ADDR=0xFFFE, free-run.
   - Expected: origaddr_o FFFE, FFFF, 0000, 0001 (wrap).
6. Mid-run, rst=0 for one cycle with branch_i=1.
   - Expected: next cycle addr_o=RESET_ADDR with req_o=1; v_o stays 0 until 2 cycles later; no stale instruction is delivered.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared core widths and fetch buffer types
package fetch_stage_pkg;

  localparam int unsigned CORE_ADDR_W = 16;
  localparam int unsigned CORE_INST_W = 32;
  localparam logic [CORE_ADDR_W-1:0] CORE_RESET_ADDR = '0;

  localparam int unsigned FETCH_BUF_DEPTH = 2;

  typedef logic [1:0] fetch_cnt_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry instruction buffer between memory return and decode
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DW = CORE_INST_W + CORE_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output fetch_cnt_t    count,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem [FETCH_BUF_DEPTH];
  logic          rd_ptr;
  logic          wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + fetch_cnt_t'(push) - fetch_cnt_t'(pop);
    end
  end

  // Storage is cleared only by reset so the head reads 0 afterwards; flush just rewinds pointers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  assign head = mem[rd_ptr];

  no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && !flush && count == fetch_cnt_t'(FETCH_BUF_DEPTH)));

  no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(pop && !flush && count == '0));

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: pc generation, 1-cycle memory, buffered hand-off to decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W     = CORE_ADDR_W,
  parameter int unsigned       INST_W     = CORE_INST_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(CORE_RESET_ADDR),
  parameter int unsigned       ADDR_INC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] baddr_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [INST_W-1:0] inst_i,
  output logic              v_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] origaddr_o,
  input  logic              stall_i
);

  logic [ADDR_W-1:0]        pc;
  logic                     inflight;
  logic [ADDR_W-1:0]        inflight_addr;
  fetch_cnt_t               count;
  logic [INST_W+ADDR_W-1:0] head;
  logic                     pop;
  logic                     push;
  logic [2:0]               occupancy;
  logic                     issue;

  // A branch squashes delivery in the same cycle, so decode never sees an old-path word.
  assign v_o = (count != '0) && !branch_i && rst;
  assign pop = v_o && !stall_i;

  // Words owed to decode after this cycle's pop: buffered plus the one still in memory.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = occupancy < 3'(FETCH_BUF_DEPTH);
  assign req_o     = issue && !branch_i && rst;
  assign addr_o    = pc;

  assign push = inflight && !branch_i && rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc            <= RESET_ADDR;
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else if (branch_i) begin
      pc       <= baddr_i;
      inflight <= 1'b0;
    end else if (req_o) begin
      pc            <= pc + ADDR_W'(ADDR_INC);
      inflight      <= 1'b1;
      inflight_addr <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DW(INST_W + ADDR_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(branch_i),
    .push (push),
    .din  ({inst_i, inflight_addr}),
    .pop  (pop),
    .count(count),
    .head (head)
  );

  assign inst_o     = head[INST_W+ADDR_W-1:ADDR_W];
  assign origaddr_o = head[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table, wrap sequence and randomized model check for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        branch_i = 1'b0;
  logic [15:0] baddr_i = '0;
  logic        stall_i = 1'b0;

  logic        req1, v1, req2, v2;
  logic [15:0] addr1, orig1, addr2, orig2;
  logic [31:0] inst1_in, inst1_out, inst2_in, inst2_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .branch_i(branch_i), .baddr_i(baddr_i),
    .req_o(req1), .addr_o(addr1), .inst_i(inst1_in),
    .v_o(v1), .inst_o(inst1_out), .origaddr_o(orig1), .stall_i(stall_i)
  );

  fetch_stage #(.RESET_ADDR(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst), .branch_i(branch_i), .baddr_i(baddr_i),
    .req_o(req2), .addr_o(addr2), .inst_i(inst2_in),
    .v_o(v2), .inst_o(inst2_out), .origaddr_o(orig2), .stall_i(stall_i)
  );

  function automatic logic [31:0] word(input logic [15:0] a);
    return 32'hA000_0000 + {16'h0000, a};
  endfunction

  // Synchronous memory: data for last cycle's request, garbage otherwise.
  always @(posedge clk) begin
    inst1_in <= req1 ? word(addr1) : $urandom;
    inst2_in <= req2 ? word(addr2) : $urandom;
  end

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic [15:0] ba, input logic s);
    @(posedge clk);
    #1;
    rst = r; branch_i = b; baddr_i = ba; stall_i = s;
    @(negedge clk);
  endtask

  typedef struct {
    logic        r, b;
    logic [15:0] ba;
    logic        s;
    logic        req;
    logic        ca;
    logic [15:0] addr;
    logic        v;
    logic [15:0] orig;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic b, input logic [15:0] ba, input logic s,
                     input logic req, input logic ca, input logic [15:0] addr,
                     input logic v, input logic [15:0] orig);
    vec_t e;
    e.r = r; e.b = b; e.ba = ba; e.s = s; e.req = req; e.ca = ca; e.addr = addr; e.v = v; e.orig = orig;
    vecs.push_back(e);
  endtask

  typedef struct {
    logic [15:0] addr;
    int          ready;
  } word_t;

  initial begin
    // reset, free run, stall 5..8, branch, branch under stall with full buffer, reset+branch
    add(0,0,0,0, 0,0,16'h0000, 0,0);
    add(0,0,0,0, 0,0,16'h0000, 0,0);
    add(1,0,0,0, 1,1,16'h0000, 0,0);
    add(1,0,0,0, 1,1,16'h0001, 0,0);
    add(1,0,0,0, 1,1,16'h0002, 1,16'h0000);
    add(1,0,0,0, 1,1,16'h0003, 1,16'h0001);
    add(1,0,0,0, 1,1,16'h0004, 1,16'h0002);
    for (int i = 0; i < 4; i++) add(1,0,0,1, 0,1,16'h0005, 1,16'h0003);
    add(1,0,0,0, 1,1,16'h0005, 1,16'h0003);
    add(1,0,0,0, 1,1,16'h0006, 1,16'h0004);
    add(1,0,0,0, 1,1,16'h0007, 1,16'h0005);
    add(1,0,0,0, 1,1,16'h0008, 1,16'h0006);
    add(1,0,0,0, 1,1,16'h0009, 1,16'h0007);
    add(1,1,16'h0040,0, 0,1,16'h000A, 0,0);
    add(1,0,0,0, 1,1,16'h0040, 0,0);
    add(1,0,0,0, 1,1,16'h0041, 0,0);
    add(1,0,0,0, 1,1,16'h0042, 1,16'h0040);
    add(1,0,0,0, 1,1,16'h0043, 1,16'h0041);
    add(1,0,0,1, 0,1,16'h0044, 1,16'h0042);
    add(1,0,0,1, 0,1,16'h0044, 1,16'h0042);
    add(1,1,16'h0080,1, 0,1,16'h0044, 0,0);
    add(1,0,0,0, 1,1,16'h0080, 0,0);
    add(1,0,0,0, 1,1,16'h0081, 0,0);
    add(1,0,0,0, 1,1,16'h0082, 1,16'h0080);
    add(1,0,0,0, 1,1,16'h0083, 1,16'h0081);
    add(0,1,16'h0030,0, 0,0,16'h0000, 0,0);
    add(1,0,0,0, 1,1,16'h0000, 0,0);
    add(1,0,0,0, 1,1,16'h0001, 0,0);
    add(1,0,0,0, 1,1,16'h0002, 1,16'h0000);
    add(1,0,0,0, 1,1,16'h0003, 1,16'h0001);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].b, vecs[i].ba, vecs[i].s);
      chk("tbl_req", i, 32'(req1), 32'(vecs[i].req));
      chk("tbl_v", i, 32'(v1), 32'(vecs[i].v));
      if (vecs[i].ca) chk("tbl_addr", i, 32'(addr1), 32'(vecs[i].addr));
      if (vecs[i].v) begin
        chk("tbl_orig", i, 32'(orig1), 32'(vecs[i].orig));
        chk("tbl_inst", i, inst1_out, word(vecs[i].orig));
      end
    end

    // address wrap from a reset address near the top of the space
    step(0,0,0,0);
    step(0,0,0,0);
    for (int k = 0; k < 6; k++) begin
      logic [15:0] ea;
      logic [15:0] eo;
      step(1,0,0,0);
      ea = 16'hFFFE + 16'(k);
      eo = 16'hFFFE + 16'(k - 2);
      chk("wrap_req", k, 32'(req2), 32'd1);
      chk("wrap_addr", k, 32'(addr2), 32'(ea));
      chk("wrap_v", k, 32'(v2), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        chk("wrap_orig", k, 32'(orig2), 32'(eo));
        chk("wrap_inst", k, inst2_out, word(eo));
      end
    end

    // random traffic against a queue model of outstanding words and their ready cycles
    begin
      word_t       q[$];
      logic [15:0] pc_m;
      logic        r, b, s, ev, pop, er;
      logic [15:0] ba;
      pc_m = 16'h0000;
      for (int c = 0; c < 600; c++) begin
        r  = (c == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
        b  = ($urandom_range(0, 9) == 0);
        s  = ($urandom_range(0, 2) == 0);
        ba = 16'($urandom);
        step(r, b, ba, s);
        if (!r || b) begin
          chk("rnd_v_redirect", c, 32'(v1), 32'd0);
          chk("rnd_req_redirect", c, 32'(req1), 32'd0);
          q.delete();
          pc_m = r ? ba : 16'h0000;
        end else begin
          ev = (q.size() > 0) && (q[0].ready <= c);
          chk("rnd_v", c, 32'(v1), 32'(ev));
          if (ev) begin
            chk("rnd_orig", c, 32'(orig1), 32'(q[0].addr));
            chk("rnd_inst", c, inst1_out, word(q[0].addr));
          end
          pop = ev && !s;
          if (pop) void'(q.pop_front());
          er = q.size() < 2;
          chk("rnd_req", c, 32'(req1), 32'(er));
          if (er) begin
            word_t w;
            chk("rnd_addr", c, 32'(addr1), 32'(pc_m));
            w.addr  = pc_m;
            w.ready = c + 2;
            q.push_back(w);
            pc_m = pc_m + 16'd1;
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
